sseg_score_display_n: RTL and testbench

Parametrised successor to the fixed 4-digit score display. It converts an unsigned binary score to BCD with a sequential double-dabble engine, then time-multiplexes DIGITS common-anode/cathode seven-segment digits. It adds leading-zero blanking, per-digit decimal points, overflow saturation and tear-free display updates. In the game top level it sits on the 50 MHz clock and is fed by the game-logic tail count.

---
 rtl/sseg_score_display_n_pkg.sv | 80 ++++++++
 rtl/sseg_score_display_n_if.sv | 28 ++
 rtl/sseg_score_display_n_bin2bcd_seq.sv | 114 +++++++++++
 rtl/sseg_score_display_n.sv | 130 +++++++++++++
 tb/tb_sseg_score_display_n.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sseg_score_display_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared segment patterns, bit positions, conversion FSM states
//                and constant helper functions for the score display.
//  Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    // Segment bit positions inside the 8-bit {a..g, dp} drive word.
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Active-high patterns, dp bit cleared.
    localparam logic [7:0] c_seg_0     = 8'hFC;
    localparam logic [7:0] c_seg_1     = 8'h60;
    localparam logic [7:0] c_seg_2     = 8'hDA;
    localparam logic [7:0] c_seg_3     = 8'hF2;
    localparam logic [7:0] c_seg_4     = 8'h66;
    localparam logic [7:0] c_seg_5     = 8'hB6;
    localparam logic [7:0] c_seg_6     = 8'hBE;
    localparam logic [7:0] c_seg_7     = 8'hE0;
    localparam logic [7:0] c_seg_8     = 8'hFE;
    localparam logic [7:0] c_seg_9     = 8'hF6;
    localparam logic [7:0] c_seg_blank = 8'h00;
    localparam logic [7:0] c_seg_dash  = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_SAT   = 2'd3
    } conv_state_t;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_pattern(input logic [3:0] nib);
        logic [7:0] p;
        case (nib)
            4'd0:    p = c_seg_0;
            4'd1:    p = c_seg_1;
            4'd2:    p = c_seg_2;
            4'd3:    p = c_seg_3;
            4'd4:    p = c_seg_4;
            4'd5:    p = c_seg_5;
            4'd6:    p = c_seg_6;
            4'd7:    p = c_seg_7;
            4'd8:    p = c_seg_8;
            4'd9:    p = c_seg_9;
            default: p = c_seg_dash;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_score_display_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_score_display_n_if
//  Description : Score input, decimal points, segment/anode drive and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sseg_score_display_n_if #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 4
);
    logic [DATA_W-1:0] data;
    logic [DIGITS-1:0] dp_mask;
    logic [7:0]        sseg_a_to_dp;
    logic [DIGITS-1:0] sseg_an;
    logic              busy;
    logic              overflow;

    modport master (
        output data, dp_mask,
        input  sseg_a_to_dp, sseg_an, busy, overflow
    );

    modport slave (
        input  data, dp_mask,
        output sseg_a_to_dp, sseg_an, busy, overflow
    );
endinterface
`default_nettype wire

// File: rtl/sseg_score_display_n_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble binary-to-BCD converter that
//                saturates to all nines when the value does not fit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import sseg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 4
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                start,
    input  wire logic [DATA_W-1:0]   bin,
    output logic      [4*DIGITS-1:0] bcd,
    output logic                     ovf,
    output logic                     busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (clog2(DATA_W + 1) < 1) ? 1 : clog2(DATA_W + 1);
    localparam logic [31:0]      c_limit     = 32'(pow10(DIGITS) - 1);
    localparam logic [BCD_W-1:0] c_all_nines = {DIGITS{4'h9}};

    conv_state_t              r_state;
    conv_state_t              w_state_next;
    logic [DATA_W-1:0]        r_shreg;
    logic [BCD_W-1:0]         r_acc;
    logic [BCD_W-1:0]         w_adj;
    logic [CNT_W-1:0]         r_bitcnt;
    logic [BCD_W+DATA_W-1:0]  w_shift;
    logic                     w_sat;

    assign w_sat = (32'(bin) > c_limit);
    assign busy  = (r_state != ST_IDLE);

    // Add-3 correction precedes the shift so each nibble stays a valid digit.
    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
        w_shift = {w_adj, r_shreg} << 1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_sat ? ST_SAT : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_bitcnt == CNT_W'(1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            ST_SAT:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // bcd is written only in DONE/SAT, so partial results never leak out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg  <= '0;
            r_acc    <= '0;
            r_bitcnt <= '0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shreg  <= bin;
                        r_acc    <= '0;
                        r_bitcnt <= CNT_W'(DATA_W);
                    end
                end
                ST_SHIFT: begin
                    r_acc    <= w_shift[BCD_W+DATA_W-1 -: BCD_W];
                    r_shreg  <= w_shift[DATA_W-1:0];
                    r_bitcnt <= r_bitcnt - CNT_W'(1);
                end
                ST_DONE: begin
                    bcd <= r_acc;
                    ovf <= 1'b0;
                end
                ST_SAT: begin
                    bcd <= c_all_nines;
                    ovf <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sseg_score_display_n.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_score_display_n
//  Description : Binary score to multiplexed seven-segment display with
//                leading-zero blanking, decimal points and saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_score_display_n
    import sseg_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int DIGITS         = 4,
    parameter int CLK_HZ         = 50_000_000,
    parameter int REFRESH_HZ     = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    sseg_score_display_n_if.slave  bus
);

    localparam int SCAN_DIV = CLK_HZ / (REFRESH_HZ * DIGITS);
    localparam int CNT_W    = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
    localparam int IDX_W    = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);
    localparam logic [7:0]        c_seg_off = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] c_an_off  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [DATA_W-1:0]   r_last_data;
    logic                w_change;
    logic                w_start;
    logic                w_eng_busy;
    logic [4*DIGITS-1:0] w_disp_bcd;
    logic                w_ovf;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [DIGITS-1:0]   w_lz;
    logic [3:0]          w_nib;
    logic                w_blank;
    logic                w_dp;
    logic [7:0]          w_seg_hi;
    logic [7:0]          w_seg;
    logic [DIGITS-1:0]   w_an_hi;
    logic [DIGITS-1:0]   w_an;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    // Changes arriving mid-conversion wait here until the engine is idle.
    assign w_change = (bus.data != r_last_data);
    assign w_start  = reset & w_change & ~w_eng_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_data <= '0;
        end else if (w_start) begin
            r_last_data <= bus.data;
        end
    end

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .bin   (bus.data),
        .bcd   (w_disp_bcd),
        .ovf   (w_ovf),
        .busy  (w_eng_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // w_lz[i]: nibbles i..DIGITS-1 are all zero.
    always_comb begin
        w_lz = '0;
        w_lz[DIGITS-1] = (w_disp_bcd[4*(DIGITS-1) +: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            w_lz[i] = w_lz[i+1] && (w_disp_bcd[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        w_nib   = 4'd0;
        w_blank = 1'b0;
        w_dp    = 1'b0;
        w_an_hi = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib      = w_disp_bcd[4*i +: 4];
                w_blank    = (BLANK_LEADING != 0) && (i != 0) && w_lz[i];
                w_dp       = bus.dp_mask[i];
                w_an_hi[i] = 1'b1;
            end
        end
        w_seg_hi         = w_blank ? c_seg_blank : seg_pattern(w_nib);
        w_seg_hi[SEG_DP] = w_dp;
        w_seg            = (SEG_ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
        w_an             = (AN_ACTIVE_LOW != 0) ? ~w_an_hi : w_an_hi;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg <= c_seg_off;
            r_an  <= c_an_off;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
        end
    end

    assign bus.sseg_a_to_dp = r_seg;
    assign bus.sseg_an      = r_an;
    assign bus.busy         = w_eng_busy | w_start;
    assign bus.overflow     = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sseg_score_display_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sseg_score_display_n
//  Description : Directed bench for the score display, 8- and 16-bit builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_score_display_n;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sseg_score_display_n_if #(.DATA_W(8),  .DIGITS(4)) if8  ();
    sseg_score_display_n_if #(.DATA_W(16), .DIGITS(4)) if16 ();

    sseg_score_display_n #(
        .DATA_W(8), .DIGITS(4), .CLK_HZ(4000), .REFRESH_HZ(250),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    sseg_score_display_n #(
        .DATA_W(16), .DIGITS(4), .CLK_HZ(4000), .REFRESH_HZ(250),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (if16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic measure_busy(input bit wide, output int n);
        #1;
        n = 0;
        while ((wide ? if16.busy : if8.busy) && n < 40) begin
            n++;
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_idle(input bit wide, input string tag);
        int n;
        #1;
        n = 0;
        while ((wide ? if16.busy : if8.busy) && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_idle"}, 32'(wide ? if16.busy : if8.busy), 32'd0);
    endtask

    task automatic frame(input bit wide, input string tag,
                         input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_seg [4];
        exp_seg = '{e0, e1, e2, e3};
        for (int d = 0; d < 4; d++) begin
            logic [3:0] an_want;
            logic [3:0] an_now;
            logic [7:0] seg_now;
            bit         found;
            an_want = ~(4'b0001 << d);
            found   = 1'b0;
            seg_now = 8'h00;
            for (int c = 0; c < 40 && !found; c++) begin
                @(negedge clk); #1;
                an_now  = wide ? if16.sseg_an : if8.sseg_an;
                seg_now = wide ? if16.sseg_a_to_dp : if8.sseg_a_to_dp;
                if (an_now == an_want) found = 1'b1;
            end
            chk($sformatf("%s_d%0d_seen", tag, d), 32'(found), 32'd1);
            chk($sformatf("%s_d%0d_seg", tag, d), 32'(seg_now), 32'(exp_seg[d]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          nchg;
        logic [15:0] prev;
        logic [15:0] cur;
        logic [15:0] chg [4];

        reset        = 1'b0;
        if8.data     = '0;
        if8.dp_mask  = '0;
        if16.data    = '0;
        if16.dp_mask = '0;
        chg          = '{16'h0, 16'h0, 16'h0, 16'h0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_an8",   32'(if8.sseg_an),       32'hF);
        chk("rst_seg8",  32'(if8.sseg_a_to_dp),  32'hFF);
        chk("rst_busy8", 32'(if8.busy),          32'd0);
        chk("rst_ovf8",  32'(if8.overflow),      32'd0);
        chk("rst_an16",  32'(if16.sseg_an),      32'hF);

        // Scan order and dwell straight after release, value zero.
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] an_exp;
            an_exp = ~(4'b0001 << (k / 4));
            @(negedge clk); #1;
            chk($sformatf("scan_an_%0d", k), 32'(if8.sseg_an), 32'(an_exp));
            chk($sformatf("scan_seg_%0d", k), 32'(if8.sseg_a_to_dp),
                (k < 4) ? 32'h03 : 32'hFF);
        end

        if8.data = 8'd195;
        measure_busy(1'b0, n);
        chk("busy_len_195", 32'(n), 32'd10);
        frame(1'b0, "d195", 8'h49, 8'h09, 8'h9F, 8'hFF);

        // New value arrives while the previous conversion is still shifting.
        if8.data = 8'd7;
        prev = u_dut8.u_conv.bcd;
        nchg = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (c == 3) if8.data = 8'd200;
            cur = u_dut8.u_conv.bcd;
            if (cur != prev) begin
                if (nchg < 4) chg[nchg] = cur;
                nchg++;
                prev = cur;
            end
        end
        chk("tear_nchg", 32'(nchg),   32'd2);
        chk("tear_first", 32'(chg[0]), 32'h0007);
        chk("tear_second", 32'(chg[1]), 32'h0200);
        frame(1'b0, "d200", 8'h03, 8'h03, 8'h25, 8'hFF);

        if8.dp_mask = 4'b0100;
        if8.data    = 8'd5;
        wait_idle(1'b0, "dp5");
        frame(1'b0, "dp5", 8'h49, 8'hFF, 8'hFE, 8'hFF);
        if8.dp_mask = 4'b0000;

        if16.data = 16'd12345;
        #1;
        chk("sat_busy0", 32'(if16.busy),     32'd1);
        chk("sat_ovf0",  32'(if16.overflow), 32'd0);
        @(negedge clk); #1;
        chk("sat_busy1", 32'(if16.busy),     32'd1);
        chk("sat_ovf1",  32'(if16.overflow), 32'd0);
        @(negedge clk); #1;
        chk("sat_ovf2",  32'(if16.overflow), 32'd1);
        chk("sat_busy2", 32'(if16.busy),     32'd0);
        frame(1'b1, "sat", 8'h09, 8'h09, 8'h09, 8'h09);

        if16.data = 16'd42;
        wait_idle(1'b1, "d42");
        chk("d42_ovf", 32'(if16.overflow), 32'd0);
        frame(1'b1, "d42", 8'h25, 8'h99, 8'hFF, 8'hFF);

        if16.data = 16'd9999;
        wait_idle(1'b1, "d9999");
        chk("d9999_ovf", 32'(if16.overflow), 32'd0);
        frame(1'b1, "d9999", 8'h09, 8'h09, 8'h09, 8'h09);

        if16.data = 16'd10000;
        wait_idle(1'b1, "d10000");
        chk("d10000_ovf", 32'(if16.overflow), 32'd1);

        // Asynchronous reset in the middle of a shift sequence.
        if8.data = 8'd9;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_an8",   32'(if8.sseg_an),      32'hF);
        chk("mr_seg8",  32'(if8.sseg_a_to_dp), 32'hFF);
        chk("mr_busy8", 32'(if8.busy),         32'd0);
        chk("mr_ovf16", 32'(if16.overflow),    32'd0);
        chk("mr_an16",  32'(if16.sseg_an),     32'hF);
        @(negedge clk); #1;
        reset = 1'b1;
        measure_busy(1'b0, n);
        chk("mr_busy_len", 32'(n), 32'd10);
        frame(1'b0, "mr9", 8'h09, 8'hFF, 8'hFF, 8'hFF);
        wait_idle(1'b1, "mr16");
        chk("mr_ovf16_again", 32'(if16.overflow), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
